// File: rtl/tick_monitor_if.sv
// Tick monitor bus: raw tick input plus every measurement/status output of the monitor.
// Latency: none; this file only groups wires.
// Backpressure: none; the tick stream is a free-running pulse train.
//
// Ports (via modports):
//   master : drives tick_in, observes period/period_valid/locked/early_err/late_err/fault_cnt
//   slave  : the monitor itself (receives tick_in, drives the status outputs)
interface tick_monitor_if #(
  parameter int EXPECT_CYC = 25_000_000,
  parameter int TOL_CYC    = 1000
);
  localparam int W = $clog2(EXPECT_CYC + TOL_CYC + 1) + 1;

  logic         tick_in;
  logic [W-1:0] period;
  logic         period_valid;
  logic         locked;
  logic         early_err;
  logic         late_err;
  logic [7:0]   fault_cnt;

  modport master (
    output tick_in,
    input  period, period_valid, locked, early_err, late_err, fault_cnt
  );

  modport slave (
    input  tick_in,
    output period, period_valid, locked, early_err, late_err, fault_cnt
  );
endinterface

// File: rtl/tick_monitor.sv
// Tick monitor: measures tick-to-tick intervals, declares lock, flags early/missing ticks.
// Latency: outputs registered one cycle after the tick is seen (+2 cycles with TICK_MON_SYNC_EN).
// Backpressure: none; every tick is consumed on arrival.
//
// Optional build macro: TICK_MON_SYNC_EN -- adds a 2-flop synchronizer and rising-edge
// detector on tick_in so it may be asynchronous or a multi-cycle level.
//
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   bus.tick_in        : tick pulse
//   bus.period         : last measured interval (cycles), bus.period_valid strobes on update
//   bus.locked         : LOCK_COUNT consecutive in-tolerance intervals seen
//   bus.early_err      : strobe, interval shorter than EXPECT_CYC-TOL_CYC
//   bus.late_err       : strobe, no tick within EXPECT_CYC+TOL_CYC cycles
//   bus.fault_cnt      : saturating count of early/late events
module tick_monitor #(
  parameter int EXPECT_CYC = 25_000_000,
  parameter int TOL_CYC    = 1000,
  parameter int LOCK_COUNT = 3
) (
  input  logic          clk,
  input  logic          rst,
  tick_monitor_if.slave bus
);
  localparam int W  = $clog2(EXPECT_CYC + TOL_CYC + 1) + 1;
  localparam int GW = $clog2(LOCK_COUNT + 1);

  localparam logic [W-1:0]  LO_CYC = W'(EXPECT_CYC - TOL_CYC);
  localparam logic [W-1:0]  HI_CYC = W'(EXPECT_CYC + TOL_CYC);
  localparam logic [GW-1:0] LOCK_G = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

  state_t        state, state_n;
  logic [W-1:0]  cnt, cnt_n;
  logic [GW-1:0] good, good_n;
  logic [W-1:0]  period_q, period_n;
  logic          pv_q, pv_n;
  logic          locked_q, locked_n;
  logic          early_q, early_n;
  logic          late_q, late_n;
  logic [7:0]    fcnt_q, fcnt_n;
  logic          tick;
  logic [GW:0]   good_inc;

`ifdef TICK_MON_SYNC_EN
  // Two synchronizer flops, third flop holds the previous level for edge detection.
  logic [2:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], bus.tick_in};
  end
  assign tick = sync_q[1] & ~sync_q[2];
`else
  assign tick = bus.tick_in;
`endif

  // One extra bit so the lock comparison cannot overflow at saturation.
  assign good_inc = {1'b0, good} + (GW + 1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      good     <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      early_q  <= 1'b0;
      late_q   <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      good     <= good_n;
      period_q <= period_n;
      pv_q     <= pv_n;
      locked_q <= locked_n;
      early_q  <= early_n;
      late_q   <= late_n;
      fcnt_q   <= fcnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    good_n   = good;
    period_n = period_q;
    pv_n     = 1'b0;
    locked_n = locked_q;
    early_n  = 1'b0;
    late_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (tick) begin
          state_n = SEARCH;
          cnt_n   = W'(1);
          good_n  = '0;
        end
      end
      SEARCH, LOCKED: begin
        if (tick) begin
          // The tick wins over a simultaneous timeout, so cnt == HI_CYC is still good.
          period_n = cnt;
          pv_n     = 1'b1;
          cnt_n    = W'(1);
          if (cnt >= LO_CYC) begin
            good_n = (good == LOCK_G) ? good : good_inc[GW-1:0];
            if (good_inc >= {1'b0, LOCK_G}) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
            end
          end else begin
            early_n  = 1'b1;
            good_n   = '0;
            state_n  = SEARCH;
            locked_n = 1'b0;
          end
        end else if (cnt == HI_CYC) begin
          late_n   = 1'b1;
          locked_n = 1'b0;
          good_n   = '0;
          state_n  = IDLE;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        good_n  = '0;
      end
    endcase
    fcnt_n = fcnt_q;
    if ((early_n || late_n) && fcnt_q != 8'hFF) fcnt_n = fcnt_q + 8'd1;
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.locked       = locked_q;
  assign bus.early_err    = early_q;
  assign bus.late_err     = late_q;
  assign bus.fault_cnt    = fcnt_q;
endmodule

// File: tb/tb_tick_monitor.sv
module tb_tick_monitor;
  localparam int EXP = 20;
  localparam int TOL = 2;
  localparam int LCK = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  tick_monitor_if #(.EXPECT_CYC(EXP), .TOL_CYC(TOL)) bus ();

  tick_monitor #(.EXPECT_CYC(EXP), .TOL_CYC(TOL), .LOCK_COUNT(LCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int   gap;      // cycles since previous tick
    logic pv;
    int   period;
    logic early;
    logic locked;
    int   fcnt;
    string name;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, sample 1 time unit later.
  task automatic cyc(input logic t, input logic r);
    bus.tick_in = t;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  // gap-1 quiet cycles then a tick; counts any strobe seen in the quiet cycles.
  task automatic tick_after(input int gap, output int stray);
    stray = 0;
    for (int i = 0; i < gap - 1; i++) begin
      cyc(1'b0, 1'b0);
      stray += int'(bus.period_valid) + int'(bus.early_err) + int'(bus.late_err);
    end
    cyc(1'b1, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, int'(bus.period), 0);
    chk({tag, "_pv"}, int'(bus.period_valid), 0);
    chk({tag, "_locked"}, int'(bus.locked), 0);
    chk({tag, "_early"}, int'(bus.early_err), 0);
    chk({tag, "_late"}, int'(bus.late_err), 0);
    chk({tag, "_fcnt"}, int'(bus.fault_cnt), 0);
  endtask

  initial begin
    int stray;
    int early_seen;

    // gap, pv, period, early, locked, fcnt
    tbl[0]  = '{5,  1'b0, 0,  1'b0, 1'b0, 0, "first_tick"};
    tbl[1]  = '{20, 1'b1, 20, 1'b0, 1'b0, 0, "nom_1"};
    tbl[2]  = '{20, 1'b1, 20, 1'b0, 1'b0, 0, "nom_2"};
    tbl[3]  = '{20, 1'b1, 20, 1'b0, 1'b1, 0, "nom_lock"};
    tbl[4]  = '{15, 1'b1, 15, 1'b1, 1'b0, 1, "early15"};
    tbl[5]  = '{20, 1'b1, 20, 1'b0, 1'b0, 1, "relock_1"};
    tbl[6]  = '{20, 1'b1, 20, 1'b0, 1'b0, 1, "relock_2"};
    tbl[7]  = '{20, 1'b1, 20, 1'b0, 1'b1, 1, "relock_3"};
    tbl[8]  = '{18, 1'b1, 18, 1'b0, 1'b1, 1, "tol_lo18"};
    tbl[9]  = '{22, 1'b1, 22, 1'b0, 1'b1, 1, "tol_hi22"};
    tbl[10] = '{17, 1'b1, 17, 1'b1, 1'b0, 2, "early17"};
    tbl[11] = '{20, 1'b1, 20, 1'b0, 1'b0, 2, "lock_a"};
    tbl[12] = '{20, 1'b1, 20, 1'b0, 1'b0, 2, "lock_b"};
    tbl[13] = '{20, 1'b1, 20, 1'b0, 1'b1, 2, "lock_c"};

    bus.tick_in = 1'b0;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);   // tick during reset is ignored
    chk_all_zero("reset");
    cyc(1'b0, 1'b0);

    for (int k = 0; k < 14; k++) begin
      tick_after(tbl[k].gap, stray);
      chk({tbl[k].name, "_stray"}, stray, 0);
      chk({tbl[k].name, "_pv"}, int'(bus.period_valid), int'(tbl[k].pv));
      if (tbl[k].pv) chk({tbl[k].name, "_period"}, int'(bus.period), tbl[k].period);
      chk({tbl[k].name, "_early"}, int'(bus.early_err), int'(tbl[k].early));
      chk({tbl[k].name, "_late"}, int'(bus.late_err), 0);
      chk({tbl[k].name, "_locked"}, int'(bus.locked), int'(tbl[k].locked));
      chk({tbl[k].name, "_fcnt"}, int'(bus.fault_cnt), tbl[k].fcnt);
    end

    // Missing tick: cnt reaches 22 on the 21st quiet edge, timeout fires on the 22nd.
    stray = 0;
    for (int i = 0; i < 21; i++) begin
      cyc(1'b0, 1'b0);
      stray += int'(bus.late_err) + int'(bus.early_err) + int'(bus.period_valid);
    end
    chk("late_pre_stray", stray, 0);
    chk("late_pre_locked", int'(bus.locked), 1);
    cyc(1'b0, 1'b0);
    chk("late_strobe", int'(bus.late_err), 1);
    chk("late_locked", int'(bus.locked), 0);
    chk("late_fcnt", int'(bus.fault_cnt), 3);
    cyc(1'b0, 1'b0);
    chk("late_one_cycle", int'(bus.late_err), 0);
    tick_after(7, stray);
    chk("restart_pv", int'(bus.period_valid), 0);
    chk("restart_late", int'(bus.late_err), 0);
    tick_after(20, stray);
    chk("restart2_pv", int'(bus.period_valid), 1);
    chk("restart2_period", int'(bus.period), 20);
    chk("restart2_locked", int'(bus.locked), 0);
    tick_after(20, stray);
    tick_after(20, stray);
    chk("prereset_locked", int'(bus.locked), 1);

    // Reset in the middle of a locked interval.
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk_all_zero("midrst");
    tick_after(5, stray);
    chk("postrst_pv", int'(bus.period_valid), 0);

    // Consecutive-cycle ticks measure 1, which is early.
    cyc(1'b1, 1'b0);
    chk("b2b_pv", int'(bus.period_valid), 1);
    chk("b2b_period", int'(bus.period), 1);
    chk("b2b_early", int'(bus.early_err), 1);
    chk("b2b_fcnt", int'(bus.fault_cnt), 1);

    // 259 more early intervals: fault count saturates at 255.
    early_seen = 0;
    for (int k = 0; k < 259; k++) begin
      tick_after(5, stray);
      early_seen += int'(bus.early_err);
      if (k == 253) chk("sat_reach", int'(bus.fault_cnt), 255);
    end
    chk("sat_early_pulses", early_seen, 259);
    chk("sat_fcnt", int'(bus.fault_cnt), 255);
    chk("sat_period", int'(bus.period), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
